lsu_store_buffer: RTL and testbench

- Load/store front end sitting directly upstream of data_memory, between the MEM pipeline stage and the memory port.
- Accepts load/store requests over a valid/ready handshake and checks alignment and funct3.
- Posts stores into an in-order store buffer that drains one entry per granted cycle.
- Serialises loads behind all older buffered stores, then returns a sign/zero-extended load result with a registered response.

---
 rtl/lsu_store_buffer.sv | 191 +++++++++++++++++++
 tb/tb_lsu_store_buffer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer
//   Load/store front end sitting directly in front of data_memory. Requests
//   arrive over a valid/ready handshake and are checked for alignment and a
//   legal funct3. Stores are posted into an in-order buffer that drains one
//   entry per granted memory cycle. Loads wait behind every older buffered
//   store, then read memory and return a sign/zero-extended result through a
//   registered one-cycle response.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   req_*             request channel (valid/ready, we, funct3, addr, wdata)
//   rsp_*             one-cycle response pulse with load data or error flag
//   stb_empty         store buffer empty (usable as a fence condition)
//   mem_gnt           shared memory port granted this cycle
//   mem_*             memory port; mem_rdata is combinational read data,
//                     low-aligned for byte/half accesses
module lsu_store_buffer #(
    parameter int unsigned STB_DEPTH = 4,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              stb_empty,
    input  logic              mem_gnt,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [1:0]        mem_byte_sel,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned PTR_W = (STB_DEPTH > 1) ? $clog2(STB_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        READ,
        RESP
    } state_t;

    state_t            state;

    logic [ADDR_W-1:0] stb_addr [STB_DEPTH];
    logic [31:0]       stb_data [STB_DEPTH];
    logic [1:0]        stb_sel  [STB_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    logic [ADDR_W-1:0] ld_addr;
    logic [2:0]        ld_funct3;

    logic              accept;
    logic              req_err;
    logic              push;
    logic              pop;
    logic              read_fire;
    logic [31:0]       load_ext;

    assign req_ready = (state == IDLE) && (count < CNT_W'(STB_DEPTH));
    assign accept    = req_valid && req_ready;
    assign stb_empty = (count == '0);

    // Illegal size, signed-store encodings, load 110, and misalignment.
    always_comb begin
        req_err = 1'b0;
        if (req_funct3[1:0] == 2'b11)
            req_err = 1'b1;
        else if (req_we && req_funct3[2])
            req_err = 1'b1;
        else if (!req_we && (req_funct3 == 3'b110))
            req_err = 1'b1;
        else if ((req_funct3[1:0] == 2'b01) && req_addr[0])
            req_err = 1'b1;
        else if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
            req_err = 1'b1;
    end

    assign push      = accept && req_we && !req_err;
    // The buffer drains whenever the port is granted, except while a load
    // owns the port; a load only reaches READ once the buffer is empty.
    assign pop       = (state != READ) && (count != '0) && mem_gnt;
    assign read_fire = (state == READ) && mem_gnt;

    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        mem_r_en     = 1'b0;
        mem_w_en     = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_byte_sel = '0;
        if (read_fire) begin
            mem_r_en     = 1'b1;
            mem_addr     = 32'(ld_addr);
            mem_byte_sel = ld_funct3[1:0];
        end else if (pop) begin
            mem_w_en     = 1'b1;
            mem_addr     = 32'(stb_addr[rd_ptr]);
            mem_wdata    = stb_data[rd_ptr];
            mem_byte_sel = stb_sel[rd_ptr];
        end
    end

    // funct3[2] selects zero extension.
    always_comb begin
        case (ld_funct3[1:0])
            2'b00:   load_ext = {{24{~ld_funct3[2] & mem_rdata[7]}},  mem_rdata[7:0]};
            2'b01:   load_ext = {{16{~ld_funct3[2] & mem_rdata[15]}}, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // Entry storage carries no reset; validity is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            stb_addr[wr_ptr] <= req_addr;
            stb_data[wr_ptr] <= req_wdata;
            stb_sel[wr_ptr]  <= req_funct3[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ld_addr   <= '0;
            ld_funct3 <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            count     <= count_next;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end else if (!req_we) begin
                            ld_addr   <= req_addr;
                            ld_funct3 <= req_funct3;
                            state     <= (count_next == '0) ? READ : DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Leave as the last older store pops so each buffered
                    // store costs exactly one granted cycle.
                    if (count_next == '0)
                        state <= READ;
                end
                READ: begin
                    if (mem_gnt) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_ext;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_store_buffer.sv
module tb_lsu_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stb_empty;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [1:0]  mem_byte_sel;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_store_buffer #(
        .STB_DEPTH(4),
        .ADDR_W   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .stb_empty   (stb_empty),
        .mem_gnt     (mem_gnt),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .mem_byte_sel(mem_byte_sel),
        .mem_rdata   (mem_rdata)
    );

    // Byte-addressed memory: combinational, little-endian, low-aligned read.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ref_save[256];
    logic       mem_clear;
    logic       pre_we;
    logic [7:0] pre_addr;
    logic [7:0] pre_data;

    assign mem_rdata = {mem[8'(mem_addr[7:0] + 8'd3)], mem[8'(mem_addr[7:0] + 8'd2)],
                        mem[8'(mem_addr[7:0] + 8'd1)], mem[mem_addr[7:0]]};

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else begin
            if (pre_we) mem[pre_addr] <= pre_data;
            if (mem_w_en) begin
                mem[mem_addr[7:0]] <= mem_wdata[7:0];
                if (mem_byte_sel != 2'b00)
                    mem[8'(mem_addr[7:0] + 8'd1)] <= mem_wdata[15:8];
                if (mem_byte_sel == 2'b10) begin
                    mem[8'(mem_addr[7:0] + 8'd2)] <= mem_wdata[23:16];
                    mem[8'(mem_addr[7:0] + 8'd3)] <= mem_wdata[31:24];
                end
            end
        end
    end

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  sel;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    int checks   = 0;
    int failures = 0;
    int access_seen = 0;
    int rsp_seen    = 0;
    bit watch = 1'b0;
    bit prev_rsp = 1'b0;

    function automatic bit exp_err(bit we, logic [2:0] f3, logic [31:0] a);
        if (f3[1:0] == 2'b11) return 1'b1;
        if (we && f3[2]) return 1'b1;
        if (!we && f3 == 3'b110) return 1'b1;
        if (f3[1:0] == 2'b01 && a[0]) return 1'b1;
        if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = ref_mem[a[7:0]];
        b1 = ref_mem[8'(a[7:0] + 8'd1)];
        b2 = ref_mem[8'(a[7:0] + 8'd2)];
        b3 = ref_mem[8'(a[7:0] + 8'd3)];
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    // Scoreboard monitor: responses and memory writes are popped and compared.
    always @(negedge clk) begin
        rsp_t e;
        wr_t  w;
        if (mem_r_en || mem_w_en) begin
            checks++;
            if (mem_r_en && mem_w_en) begin
                failures++;
                $display("FAIL en_exclusive: r_en=%b w_en=%b required not both 1", mem_r_en, mem_w_en);
            end
        end
        if (watch && (mem_r_en || mem_w_en)) access_seen++;
        if (rsp_valid) begin
            rsp_seen++;
            checks++;
            if (prev_rsp) begin
                failures++;
                $display("FAIL rsp_pulse: rsp_valid high two cycles, required one");
            end else if (rsp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: err=%b rdata=%h, required no response", rsp_err, rsp_rdata);
            end else begin
                e = rsp_q.pop_front();
                if (rsp_err !== e.err || rsp_rdata !== e.data) begin
                    failures++;
                    $display("FAIL rsp_data: got err=%b rdata=%h, required err=%b rdata=%h",
                             rsp_err, rsp_rdata, e.err, e.data);
                end
            end
        end
        prev_rsp = rsp_valid;
        if (mem_w_en) begin
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: addr=%h data=%h sel=%b, required no write",
                         mem_addr, mem_wdata, mem_byte_sel);
            end else begin
                w = wr_q.pop_front();
                if (mem_addr !== w.addr || mem_wdata !== w.data || mem_byte_sel !== w.sel) begin
                    failures++;
                    $display("FAIL wr_order: got addr=%h data=%h sel=%b, required addr=%h data=%h sel=%b",
                             mem_addr, mem_wdata, mem_byte_sel, w.addr, w.data, w.sel);
                end
            end
        end
    end

    task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bit done;
        done = 1'b0;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                done = 1'b1;
                if (exp_err(we, f3, a)) begin
                    rsp_q.push_back('{1'b1, 32'h0});
                end else if (we) begin
                    ref_mem[a[7:0]] = d[7:0];
                    if (f3[1:0] != 2'b00) ref_mem[8'(a[7:0] + 8'd1)] = d[15:8];
                    if (f3[1:0] == 2'b10) begin
                        ref_mem[8'(a[7:0] + 8'd2)] = d[23:16];
                        ref_mem[8'(a[7:0] + 8'd3)] = d[31:24];
                    end
                    wr_q.push_back('{a, d, f3[1:0]});
                end else begin
                    rsp_q.push_back('{1'b0, ref_load(f3, a)});
                end
                #1;
            end else begin
                @(posedge clk);
            end
        end
        req_valid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL send_timeout: addr=%h not accepted, required acceptance", a);
        end
    endtask

    task automatic wait_quiet(input string name);
        bit quiet;
        quiet = 1'b0;
        for (int i = 0; i < 200 && !quiet; i++) begin
            @(negedge clk);
            quiet = (rsp_q.size() == 0) && (wr_q.size() == 0) && stb_empty && req_ready;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL %s_drain: rsp_q=%0d wr_q=%0d stb_empty=%b, required all drained",
                     name, rsp_q.size(), wr_q.size(), stb_empty);
        end
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] v);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; pre_we = 1'b0;
        pre_addr = '0; pre_data = '0; mem_clear = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1 mem_clear = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata, mem_r_en, mem_w_en, mem_addr, mem_wdata, mem_byte_sel} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: rsp_valid=%b rsp_err=%b rdata=%h r_en=%b w_en=%b addr=%h, required all 0",
                     rsp_valid, rsp_err, rsp_rdata, mem_r_en, mem_w_en, mem_addr);
        end
        checks++;
        if (stb_empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_stb_empty: got %b required 1", stb_empty);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || stb_empty !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL release_state: req_ready=%b stb_empty=%b rsp_valid=%b, required 1 1 0",
                     req_ready, stb_empty, rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load;
        mem_gnt = 1'b1;
        send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        send(1'b0, 3'b010, 32'h10, 32'h0);
        // acceptance edge E0 just passed: READ cycle, then response
        @(negedge clk);
        checks++;
        if (mem_r_en !== 1'b1 || rsp_valid !== 1'b0 || mem_addr !== 32'h10 || mem_byte_sel !== 2'b10) begin
            failures++;
            $display("FAIL load_read_cycle: r_en=%b rsp_valid=%b addr=%h sel=%b, required 1 0 00000010 10",
                     mem_r_en, rsp_valid, mem_addr, mem_byte_sel);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL load_latency: rsp_valid=%b required 1", rsp_valid);
        end
        wait_quiet("store_load");
    endtask

    task automatic test_extension;
        mem_gnt = 1'b0;
        preload(8'h20, 8'h80);
        preload(8'h22, 8'h01);
        preload(8'h23, 8'h80);
        mem_gnt = 1'b1;
        send(1'b0, 3'b000, 32'h20, 32'h0);   // 0xFFFFFF80
        send(1'b0, 3'b100, 32'h20, 32'h0);   // 0x00000080
        send(1'b0, 3'b001, 32'h22, 32'h0);   // 0xFFFF8001
        send(1'b0, 3'b101, 32'h22, 32'h0);   // 0x00008001
        wait_quiet("extension");
    endtask

    task automatic test_full;
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++)
            send(1'b1, 3'b010, 32'h40 + 32'(i * 4), 32'hA0A0_0000 + 32'(i));
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || stb_empty !== 1'b0) begin
            failures++;
            $display("FAIL full_ready: req_ready=%b stb_empty=%b, required 0 0", req_ready, stb_empty);
        end
        @(posedge clk); #1;
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h50; req_wdata = 32'h5555_5555; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0) begin
                failures++;
                $display("FAIL full_block%0d: req_ready=%b required 0", i, req_ready);
            end
            @(posedge clk);
        end
        #1 req_valid = 1'b0;
        mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (mem_w_en !== 1'b1) begin
                failures++;
                $display("FAIL drain_cycle%0d: w_en=%b required 1", i, mem_w_en);
            end
        end
        @(negedge clk);
        checks++;
        if (stb_empty !== 1'b1 || req_ready !== 1'b1 || mem_w_en !== 1'b0) begin
            failures++;
            $display("FAIL drain_done: stb_empty=%b req_ready=%b w_en=%b, required 1 1 0",
                     stb_empty, req_ready, mem_w_en);
        end
        @(posedge clk); #1;
        send(1'b0, 3'b010, 32'h48, 32'h0);
        wait_quiet("full");
    endtask

    task automatic test_errors;
        mem_gnt = 1'b1;
        access_seen = 0;
        watch = 1'b1;
        send(1'b0, 3'b010, 32'h13, 32'h0);
        send(1'b1, 3'b001, 32'h01, 32'h0000_ABCD);
        send(1'b0, 3'b011, 32'h00, 32'h0);
        send(1'b0, 3'b110, 32'h00, 32'h0);
        wait_quiet("errors");
        watch = 1'b0;
        checks++;
        if (access_seen != 0) begin
            failures++;
            $display("FAIL err_no_access: saw %0d memory enables, required 0", access_seen);
        end
        checks++;
        if (mem[1] !== 8'h00 || mem[2] !== 8'h00) begin
            failures++;
            $display("FAIL err_mem_untouched: mem[1]=%h mem[2]=%h, required 00 00", mem[1], mem[2]);
        end
    endtask

    task automatic test_reset_drain;
        mem_gnt = 1'b0;
        ref_save = ref_mem;
        send(1'b1, 3'b010, 32'h60, 32'h1111_1111);
        send(1'b1, 3'b010, 32'h64, 32'h2222_2222);
        send(1'b0, 3'b010, 32'h60, 32'h0);
        @(negedge clk);
        checks++;
        if (stb_empty !== 1'b0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset_drain: stb_empty=%b req_ready=%b, required 0 0", stb_empty, req_ready);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata, mem_r_en, mem_w_en, mem_addr, mem_wdata, mem_byte_sel} !== '0
            || stb_empty !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: rsp_valid=%b w_en=%b addr=%h stb_empty=%b, required 0 0 0 1",
                     rsp_valid, mem_w_en, mem_addr, stb_empty);
        end
        rsp_q.delete();
        wr_q.delete();
        ref_mem = ref_save;
        @(posedge clk); #1 rst = 1'b1;
        mem_gnt = 1'b1;
        access_seen = 0;
        rsp_seen = 0;
        watch = 1'b1;
        repeat (10) @(negedge clk);
        watch = 1'b0;
        checks++;
        if (access_seen != 0 || rsp_seen != 0) begin
            failures++;
            $display("FAIL reset_discard: accesses=%0d responses=%0d, required 0 0", access_seen, rsp_seen);
        end
        checks++;
        if (mem[8'h60] !== 8'h00 || mem[8'h64] !== 8'h00 || stb_empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_mem: mem[60]=%h mem[64]=%h stb_empty=%b, required 00 00 1",
                     mem[8'h60], mem[8'h64], stb_empty);
        end
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_extension;
        test_full;
        test_errors;
        test_reset_drain;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
